// File: rtl/serial_encoder_8_3_pkg.sv
// Shared state enumeration, width constants and popcount helper for the 8-to-3 serial encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_encoder_8_3_pkg;

    localparam int VEC_W = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Number of set lines in a request vector (0..VEC_W).
    function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < VEC_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/serial_encoder_8_3_prio_enc.sv
// Set-bit finder: index of the lowest (lsb_first=1) or highest (lsb_first=0) set bit of vec.
// Latency: purely combinational.
// Backpressure: none; idx is 0 when vec is all-zero (any = 0).
module prio_enc_8_3
    import serial_encoder_8_3_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    input  logic             lsb_first,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Last match in the scan wins, so scan from the opposite end of the preferred one.
    always_comb begin
        idx = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (lsb_first) begin
                if (vec[VEC_W-1-i]) idx = IDX_W'(VEC_W - 1 - i);
            end else begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/serial_encoder_8_3.sv
// Captures a multi-hot vector and emits one beat per set bit (binary index), zero vector -> one out_none beat.
// Latency: first beat one cycle after capture; N set bits take N beats, then one idle cycle before the next capture.
// Backpressure: in_ready low while a vector is being drained; beats hold stable while out_ready is low.
module serial_encoder_8_3
    import serial_encoder_8_3_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [CNT_W-1:0] out_cnt
);

    state_t           state;
    logic [VEC_W-1:0] mask;
    logic [VEC_W-1:0] mask_nxt;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_any;
    logic             nxt_single;

    // Mask as it will look after this edge: freshly captured, or with the emitted bit removed.
    always_comb begin
        mask_nxt = mask;
        if (in_valid && in_ready) begin
            mask_nxt = in_vec;
        end else if (out_valid && out_ready) begin
            mask_nxt = mask & ~(VEC_W'(1) << out_idx);
        end
    end

    prio_enc_8_3 u_prio (
        .vec       (mask_nxt),
        .lsb_first (LSB_FIRST != 0),
        .idx       (nxt_idx),
        .any       (nxt_any)
    );

    assign nxt_single = nxt_any && ((mask_nxt & (mask_nxt - VEC_W'(1))) == '0);

    // Control FSM; beat fields are registered from the look-ahead mask so they are ready the cycle after an update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_none  <= 1'b0;
            out_cnt   <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                state     <= BUSY;
                mask      <= in_vec;
                out_cnt   <= popcount(in_vec);
                out_valid <= 1'b1;
                in_ready  <= 1'b0;
                out_idx   <= nxt_idx;
                out_none  <= !nxt_any;
                // An empty vector still yields one (final) beat.
                out_last  <= nxt_any ? nxt_single : 1'b1;
            end
        end else begin
            if (out_ready) begin
                if (out_last) begin
                    // Drop to IDLE; in_ready only rises next cycle, giving the idle gap between vectors.
                    state     <= IDLE;
                    mask      <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    out_idx   <= '0;
                    out_last  <= 1'b0;
                    out_none  <= 1'b0;
                    out_cnt   <= '0;
                end else begin
                    mask     <= mask_nxt;
                    out_idx  <= nxt_idx;
                    out_last <= nxt_single;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_encoder_8_3.sv
module tb_serial_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       rdy_l, vld_l, last_l, none_l;
    logic [2:0] idx_l;
    logic [3:0] cnt_l;
    logic       rdy_m, vld_m, last_m, none_m;
    logic [2:0] idx_m;
    logic [3:0] cnt_m;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: a queue of expected indices per scan order.
    int q_l[$];
    int q_m[$];
    bit m_busy = 1'b0;
    int m_cnt  = 0;
    bit m_none = 1'b0;

    always #5 clk = ~clk;

    serial_encoder_8_3 #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_l), .in_vec(in_vec),
        .out_valid(vld_l), .out_ready(out_ready), .out_idx(idx_l), .out_last(last_l),
        .out_none(none_l), .out_cnt(cnt_l)
    );

    serial_encoder_8_3 #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m), .in_vec(in_vec),
        .out_valid(vld_m), .out_ready(out_ready), .out_idx(idx_m), .out_last(last_m),
        .out_none(none_m), .out_cnt(cnt_m)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: pop a beat on handshake, else capture when idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_l.delete();
            q_m.delete();
            m_busy = 1'b0;
            m_cnt  = 0;
            m_none = 1'b0;
        end else if (m_busy) begin
            if (out_ready) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
                if (q_l.size() == 0) m_busy = 1'b0;
            end
        end else if (in_valid) begin
            m_cnt  = $countones(in_vec);
            m_none = (in_vec == 8'h00);
            if (m_none) begin
                q_l.push_back(0);
                q_m.push_back(0);
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (in_vec[k]) begin
                        q_l.push_back(k);
                        q_m.push_front(k);
                    end
                end
            end
            m_busy = 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("vld_l", int'(vld_l), int'(m_busy));
            chk("vld_m", int'(vld_m), int'(m_busy));
            chk("rdy_l", int'(rdy_l), int'(!m_busy));
            chk("rdy_m", int'(rdy_m), int'(!m_busy));
            if (m_busy) begin
                chk("idx_l",  int'(idx_l),  q_l[0]);
                chk("idx_m",  int'(idx_m),  q_m[0]);
                chk("last_l", int'(last_l), int'(q_l.size() == 1));
                chk("last_m", int'(last_m), int'(q_m.size() == 1));
                chk("none_l", int'(none_l), int'(m_none));
                chk("none_m", int'(none_m), int'(m_none));
                chk("cnt_l",  int'(cnt_l),  m_cnt);
                chk("cnt_m",  int'(cnt_m),  m_cnt);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 50) begin
            cyc();
            n++;
        end
        if (m_busy) chk("idle_timeout", 1, 0);
    endtask

    // Present v for one cycle while idle; afterwards in_vec is scrambled (must be ignored).
    task automatic cap(input logic [7:0] v);
        wait_idle();
        in_vec   = v;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_vec   = 8'($urandom);
    endtask

    initial begin
        logic [7:0] dec;
        logic [7:0] onehot;
        int         sel;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", int'(vld_l), 0);
        chk("rst_rdy", int'(rdy_l), 1);
        chk("rst_idx", int'(idx_l), 0);
        chk("rst_last", int'(last_l), 0);
        chk("rst_none", int'(none_l), 0);
        chk("rst_cnt", int'(cnt_l), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // 0010_0100 in both scan orders.
        out_ready = 1'b1;
        cap(8'b0010_0100);
        chk("v24_b0_idx_l", int'(idx_l), 2);
        chk("v24_b0_last_l", int'(last_l), 0);
        chk("v24_b0_cnt_l", int'(cnt_l), 2);
        chk("v24_b0_idx_m", int'(idx_m), 5);
        chk("v24_model_q", q_l[0], 2);
        cyc();
        chk("v24_b1_idx_l", int'(idx_l), 5);
        chk("v24_b1_last_l", int'(last_l), 1);
        chk("v24_b1_cnt_l", int'(cnt_l), 2);
        chk("v24_b1_idx_m", int'(idx_m), 2);
        cyc();
        chk("v24_gap_vld", int'(vld_l), 0);
        chk("v24_gap_rdy", int'(rdy_l), 1);

        // Zero vector: single out_none beat.
        cap(8'h00);
        chk("z_vld", int'(vld_l), 1);
        chk("z_none", int'(none_l), 1);
        chk("z_last", int'(last_l), 1);
        chk("z_idx", int'(idx_l), 0);
        chk("z_cnt", int'(cnt_l), 0);
        cyc();
        chk("z_idle", int'(vld_l), 0);

        // 0xFF with out_ready toggling 1,0,1,0...
        cap(8'hFF);
        for (int c = 0; c < 15; c++) begin
            out_ready = (c % 2 == 0);
            chk("ff_idx", int'(idx_l), (c + 1) / 2);
            chk("ff_last", int'(last_l), int'((c + 1) / 2 == 7));
            chk("ff_cnt", int'(cnt_l), 8);
            chk("ff_none", int'(none_l), 0);
            cyc();
        end
        chk("ff_done", int'(vld_l), 0);
        out_ready = 1'b1;

        // Reset mid-vector discards the idx 7 beat.
        cap(8'b1000_0001);
        chk("r_b0_idx", int'(idx_l), 0);
        cyc();
        chk("r_b1_idx", int'(idx_l), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_vld", int'(vld_l), 0);
        chk("r_async_rdy", int'(rdy_l), 1);
        chk("r_async_idx", int'(idx_l), 0);
        chk("r_async_cnt", int'(cnt_l), 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("r_no_beat", int'(vld_l), 0);
        end

        // One-hot round trip through a 3-to-8 decode.
        for (int i = 0; i < 8; i++) begin
            onehot = 8'd1 << i;
            cap(onehot);
            dec = 8'd1 << idx_l;
            chk("dec_vld", int'(vld_l), 1);
            chk("dec_rt", int'(dec), int'(onehot));
            chk("dec_last", int'(last_l), 1);
            cyc();
        end

        // Randomised traffic, with one asynchronous reset pulse part-way.
        for (int c = 0; c < 500; c++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 9);
            if (sel == 0)      in_vec = 8'h00;
            else if (sel == 1) in_vec = 8'hFF;
            else if (sel == 2) in_vec = 8'd1 << $urandom_range(0, 7);
            else               in_vec = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            if (c == 250) begin
                #2;
                rst_n = 1'b0;
                #4;
                rst_n = 1'b1;
            end
            cyc();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_encoder_8_3.md
SERIAL_ENCODER_8_3 -- requirements
Module: serial_encoder_8_3

Interface
REQ-001 Parameter: LSB_FIRST, default 1, scan order (1 = lowest set bit first, 0 = highest set bit first).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_vec valid.
REQ-005 in_ready  output  1  block can accept a new vector.
REQ-006 in_vec  input  8  one-hot or multi-hot request vector; bit k = line k.
REQ-007 out_valid  output  1  out_idx/out_last/out_none valid.
REQ-008 out_ready  input  1  downstream accepts the current beat.
REQ-009 out_idx  output  3  binary index of the current set bit.
REQ-010 out_last  output  1  current beat is the final beat for the captured vector.
REQ-011 out_none  output  1  captured vector was all-zero.
REQ-012 out_cnt  output  4  popcount of the captured vector (0..8), held for the whole vector.

Function
REQ-013 The block SHALL be the inverse of the team's 3-to-8 decoder: each set bit k of a captured vector is emitted as one beat with out_idx = k.
REQ-014 States SHALL be IDLE and BUSY.
REQ-015 In IDLE: in_ready = 1, out_valid = 0.
REQ-016 In BUSY: in_ready = 0, out_valid = 1.
REQ-017 A handshake in_valid && in_ready at a rising edge SHALL capture in_vec into an internal pending mask, capture its popcount into out_cnt, and move the block to BUSY.
REQ-018 out_valid SHALL first assert one cycle after capture; no beat is issued in the capture cycle.
REQ-019 When the pending mask is non-zero, out_idx SHALL be the index of the lowest set bit (LSB_FIRST=1) or the highest set bit (LSB_FIRST=0) of the mask.
REQ-020 out_last = 1 exactly when the pending mask has one set bit.
REQ-021 On out_valid && out_ready, the emitted bit SHALL be cleared from the mask.
REQ-022 The state SHALL return to IDLE after the handshake with out_last = 1.
REQ-023 A zero vector SHALL produce exactly one beat with out_none = 1, out_last = 1, out_idx = 0 and out_cnt = 0.
REQ-024 out_none SHALL be 0 for every non-zero vector.
REQ-025 While out_valid = 1 and out_ready = 0, out_idx, out_last, out_none and out_cnt SHALL hold stable.
REQ-026 A new vector SHALL NOT be accepted in the cycle the last beat completes; in_ready rises the following cycle, giving one idle cycle between vectors.
REQ-027 in_vec changes while in BUSY SHALL be ignored.
REQ-028 A vector of 8'hFF SHALL produce 8 beats, with out_cnt = 8.
REQ-029 A vector with N set bits SHALL complete in N beats, with a minimum of N+1 cycles from capture to IDLE.

Reset
REQ-030 rst_n low SHALL immediately force the following, independent of clk: state IDLE, pending mask 0, out_valid 0, in_ready 1, out_idx 0, out_last 0, out_none 0, out_cnt 0.
REQ-031 A reset asserted mid-vector SHALL discard all remaining beats; no beat is emitted after reset release until a new capture.
REQ-032 The block SHALL resume normal operation on the first rising edge after rst_n deasserts.

Structure
REQ-033 A shared package SHALL hold the state enumeration (IDLE, BUSY) and the width constants VEC_W = 8, IDX_W = 3, CNT_W = 4.
REQ-034 One combinational sub-module, prio_enc_8_3, SHALL implement the set-bit finder with ports vec[7:0], lsb_first, idx[2:0], any.
REQ-035 The top level SHALL contain the state register, the mask, the popcount and the handshake logic.

Verification
REQ-036 Capture in_vec = 8'b0010_0100, out_ready = 1, LSB_FIRST = 1 -> two beats: idx 2 (last 0), then idx 5 (last 1); out_cnt = 2 on both.
REQ-037 Same vector with LSB_FIRST = 0 -> beats idx 5 then idx 2.
REQ-038 Capture in_vec = 8'h00 -> single beat: out_none = 1, out_last = 1, out_cnt = 0; then IDLE.
REQ-039 Capture in_vec = 8'hFF with out_ready toggling 1,0,1,0 -> idx 0..7 in order, each held while stalled; out_last only on idx 7.
REQ-040 Capture 8'b1000_0001, pull rst_n low after the first beat -> out_valid drops immediately, in_ready = 1, no idx 7 beat after release.
REQ-041 Loop i = 0..7: capture the one-hot vector 1<<i, then feed the emitted out_idx into the 3-to-8 decoder -> decoder output equals the original vector.
